// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: select codes, datapath widths
// and the divide-by-zero trap test applied when a command is queued.
package alu_pkg;

   localparam int ALU_W       = 8;
   localparam int Y_W         = 16;
   localparam int S_W         = 4;
   localparam int ALU_LAT_DFLT = 3;

   localparam logic [S_W-1:0] OP_ADD  = 4'd0;
   localparam logic [S_W-1:0] OP_SUB  = 4'd1;
   localparam logic [S_W-1:0] OP_INC  = 4'd2;
   localparam logic [S_W-1:0] OP_DEC  = 4'd3;
   localparam logic [S_W-1:0] OP_MUL  = 4'd4;
   localparam logic [S_W-1:0] OP_DIV  = 4'd5;
   localparam logic [S_W-1:0] OP_MOD  = 4'd6;
   localparam logic [S_W-1:0] OP_AND  = 4'd7;
   localparam logic [S_W-1:0] OP_XOR  = 4'd8;
   localparam logic [S_W-1:0] OP_OR   = 4'd9;
   localparam logic [S_W-1:0] OP_NOT  = 4'd10;
   localparam logic [S_W-1:0] OP_NAND = 4'd11;
   localparam logic [S_W-1:0] OP_SHL  = 4'd12;
   localparam logic [S_W-1:0] OP_SHR  = 4'd13;
   localparam logic [S_W-1:0] OP_ROR  = 4'd14;
   localparam logic [S_W-1:0] OP_ROL  = 4'd15;

   function automatic logic is_div_trap(input logic [S_W-1:0] s, input logic [ALU_W-1:0] b);
      return (s == OP_DIV) && (b == '0);
   endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO with occupancy count; storage is left unreset, only pointers and
// count clear on rst.
module alu_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_cnt;
   logic             w_do_pop;
   logic             w_do_push;

   assign w_do_pop  = pop && (r_cnt != '0);
   assign w_do_push = push && ((r_cnt != FULL) || w_do_pop);
   assign dout      = r_mem[r_rd];
   assign count     = r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop)  r_rd <= r_rd + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr] <= din;
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues one per clock to a fixed-latency ALU, and returns tagged
// results in order. Issue is throttled so the result FIFO can never overflow.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int CMD_DEPTH = 4,
   parameter int RES_DEPTH = 4,
   parameter int ALU_LAT   = ALU_LAT_DFLT,
   parameter int TAG_W     = 4
) (
   input  logic               clk,
   input  logic               en,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [ALU_W-1:0]   cmd_a,
   input  logic [ALU_W-1:0]   cmd_b,
   input  logic [S_W-1:0]     cmd_s,
   input  logic [TAG_W-1:0]   cmd_tag,
   output logic [ALU_W-1:0]   alu_a,
   output logic [ALU_W-1:0]   alu_b,
   output logic [S_W-1:0]     alu_s,
   input  logic [Y_W-1:0]     alu_y,
   input  logic               alu_carry,
   input  logic               alu_zero,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [Y_W-1:0]     res_y,
   output logic               res_carry,
   output logic               res_zero,
   output logic               res_err,
   output logic [TAG_W-1:0]   res_tag,
   output logic               busy
);

   localparam int CMD_W  = 2*ALU_W + S_W + 1 + TAG_W;
   localparam int RES_W  = Y_W + 3 + TAG_W;
   localparam int CCNT_W = $clog2(CMD_DEPTH) + 1;
   localparam int RCNT_W = $clog2(RES_DEPTH) + 1;
   localparam int INF_W  = $clog2(ALU_LAT + 1);

   logic                r_ok;
   logic [ALU_W-1:0]    r_alu_a;
   logic [ALU_W-1:0]    r_alu_b;
   logic [S_W-1:0]      r_alu_s;
   logic [INF_W-1:0]    r_inflight;
   logic [ALU_LAT-1:0]  r_vld_p;
   logic [ALU_LAT-1:0]  r_err_p;
   logic [TAG_W-1:0]    r_tag_p [ALU_LAT];

   logic [CMD_W-1:0]    w_cmd_din;
   logic [CMD_W-1:0]    w_cmd_dout;
   logic [CCNT_W-1:0]   w_cmd_count;
   logic [RES_W-1:0]    w_res_din;
   logic [RES_W-1:0]    w_res_dout;
   logic [RCNT_W-1:0]   w_res_count;
   logic                w_push_cmd;
   logic                w_issue;
   logic                w_capture;
   logic                w_pop_res;
   logic [ALU_W-1:0]    w_h_a;
   logic [ALU_W-1:0]    w_h_b;
   logic [S_W-1:0]      w_h_s;
   logic                w_h_err;
   logic [TAG_W-1:0]    w_h_tag;
   logic                w_cap_err;
   logic [TAG_W-1:0]    w_cap_tag;

   // Ready comes from the registered count only, so a same-cycle pop never reopens a full FIFO.
   assign cmd_ready  = r_ok && (32'(w_cmd_count) < CMD_DEPTH);
   assign w_push_cmd = cmd_valid && cmd_ready;
   assign w_cmd_din  = {cmd_a, cmd_b, cmd_s, is_div_trap(cmd_s, cmd_b), cmd_tag};
   assign {w_h_a, w_h_b, w_h_s, w_h_err, w_h_tag} = w_cmd_dout;

   assign w_issue = (w_cmd_count != '0) && ((32'(r_inflight) + 32'(w_res_count)) < RES_DEPTH);

   alu_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk   (clk),
      .rst   (en),
      .push  (w_push_cmd),
      .pop   (w_issue),
      .din   (w_cmd_din),
      .dout  (w_cmd_dout),
      .count (w_cmd_count)
   );

   always_ff @(posedge clk) begin
      if (en) begin
         r_ok       <= 1'b0;
         r_vld_p    <= '0;
         r_inflight <= '0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_s    <= '0;
      end else begin
         r_ok <= 1'b1;
         r_vld_p[0] <= w_issue;
         for (int i = 1; i < ALU_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
         case ({w_issue, w_capture})
            2'b10:   r_inflight <= r_inflight + INF_W'(1);
            2'b01:   r_inflight <= r_inflight - INF_W'(1);
            default: r_inflight <= r_inflight;
         endcase
         if (w_issue) begin
            r_alu_a <= w_h_a;
            r_alu_b <= w_h_err ? 8'd1 : w_h_b;
            r_alu_s <= w_h_s;
         end
      end
   end

   // In-flight pipe payload: only the valid bits need clearing on reset.
   always_ff @(posedge clk) begin
      r_err_p[0] <= w_h_err;
      r_tag_p[0] <= w_h_tag;
      for (int i = 1; i < ALU_LAT; i++) begin
         r_err_p[i] <= r_err_p[i-1];
         r_tag_p[i] <= r_tag_p[i-1];
      end
   end

   assign alu_a = r_alu_a;
   assign alu_b = r_alu_b;
   assign alu_s = r_alu_s;

   assign w_capture = r_vld_p[ALU_LAT-1];
   assign w_cap_err = r_err_p[ALU_LAT-1];
   assign w_cap_tag = r_tag_p[ALU_LAT-1];
   assign w_res_din = w_cap_err ? {16'hFFFF, 1'b0, 1'b0, 1'b1, w_cap_tag}
                                : {alu_y, alu_carry, alu_zero, 1'b0, w_cap_tag};
   assign w_pop_res = res_valid && res_ready;

   alu_sync_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
      .clk   (clk),
      .rst   (en),
      .push  (w_capture),
      .pop   (w_pop_res),
      .din   (w_res_din),
      .dout  (w_res_dout),
      .count (w_res_count)
   );

   // Storage is unreset, so the head is masked to keep outputs at zero while empty.
   assign res_valid = (w_res_count != '0);
   assign {res_y, res_carry, res_zero, res_err, res_tag} = res_valid ? w_res_dout : '0;
   assign busy = (w_cmd_count != '0) || (r_vld_p != '0) || (w_res_count != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a 3-cycle stand-in ALU; table vectors plus
// hand-written latency, trap, throughput, backpressure and reset sequences.
module tb_alu_cmd_sequencer;

   localparam int TAG_W = 4;

   logic              clk = 1'b0;
   logic              en;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [7:0]        cmd_a, cmd_b;
   logic [3:0]        cmd_s;
   logic [TAG_W-1:0]  cmd_tag;
   logic [7:0]        alu_a, alu_b;
   logic [3:0]        alu_s;
   logic [15:0]       alu_y;
   logic              alu_carry, alu_zero;
   logic              res_valid, res_ready;
   logic [15:0]       res_y;
   logic              res_carry, res_zero, res_err;
   logic [TAG_W-1:0]  res_tag;
   logic              busy;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.CMD_DEPTH(4), .RES_DEPTH(4), .ALU_LAT(3), .TAG_W(TAG_W)) dut (
      .clk(clk), .en(en),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s), .cmd_tag(cmd_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
      .alu_y(alu_y), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_y(res_y), .res_carry(res_carry), .res_zero(res_zero),
      .res_err(res_err), .res_tag(res_tag), .busy(busy)
   );

   // Stand-in ALU: value presented after issue edge t is visible on alu_y at edge t+3.
   function automatic logic [16:0] alu_f(input logic [7:0] a, b, input logic [3:0] s);
      logic [8:0] sum;
      case (s)
         4'd0:    begin sum = {1'b0, a} + {1'b0, b}; return {sum[8], 8'h00, sum[7:0]}; end
         4'd4:    return {1'b0, 16'(a) * 16'(b)};
         4'd5:    return (b == 8'd0) ? {1'b0, 16'hFFFF} : {1'b0, 8'h00, a / b};
         4'd8:    return {1'b0, 8'h00, a ^ b};
         4'd12:   return {a[7], 8'h00, a[6:0], 1'b0};
         default: return 17'd0;
      endcase
   endfunction

   logic [16:0] m_p1, m_p2;
   always @(posedge clk) begin
      m_p1 <= alu_f(alu_a, alu_b, alu_s);
      m_p2 <= m_p1;
   end
   assign alu_y     = m_p2[15:0];
   assign alu_carry = m_p2[16];
   assign alu_zero  = (m_p2[15:0] == 16'd0);

   typedef struct {
      logic [7:0]       a, b;
      logic [3:0]       s;
      logic [TAG_W-1:0] tag;
      logic [15:0]      y;
      logic             c, z, e;
   } vec_t;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [22:0] exp_q[$];
   int rx_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Results are consumed on the edge following a negedge where valid && ready hold.
   always @(negedge clk) begin
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
         logic [22:0] got;
         got = {res_y, res_carry, res_zero, res_err, res_tag};
         rx_cyc.push_back(cyc);
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: got %0h expected none", got);
         end else begin
            logic [22:0] want;
            want = exp_q.pop_front();
            if (got !== want) begin
               n_fail++;
               $display("FAIL result: got y=%h c=%b z=%b e=%b tag=%0d expected y=%h c=%b z=%b e=%b tag=%0d",
                        got[22:7], got[6], got[5], got[4], got[3:0],
                        want[22:7], want[6], want[5], want[4], want[3:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_res(input logic [15:0] y, input logic c, z, e, input logic [TAG_W-1:0] tag);
      exp_q.push_back({y, c, z, e, tag});
   endtask

   task automatic send(input logic [7:0] a, b, input logic [3:0] s, input logic [TAG_W-1:0] tag);
      bit ok;
      ok = 0;
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_s = s; cmd_tag = tag;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (cmd_ready) ok = 1;
         step();
      end
      cmd_valid = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
      chk("drain_left", exp_q.size(), 0);
   endtask

   vec_t vt[8];

   initial begin
      int idx;
      bit rdy;
      int hits;

      vt[0] = '{8'd15,  8'd17,  4'd4,  4'd2, 16'h00FF, 1'b0, 1'b0, 1'b0};
      vt[1] = '{8'hA5,  8'hA5,  4'd8,  4'd5, 16'h0000, 1'b0, 1'b1, 1'b0};
      vt[2] = '{8'h80,  8'h00,  4'd12, 4'd6, 16'h0000, 1'b1, 1'b1, 1'b0};
      vt[3] = '{8'd9,   8'd0,   4'd5,  4'd3, 16'hFFFF, 1'b0, 1'b0, 1'b1};
      vt[4] = '{8'd100, 8'd7,   4'd5,  4'd4, 16'd14,   1'b0, 1'b0, 1'b0};
      vt[5] = '{8'hC8,  8'h64,  4'd0,  4'd7, 16'h002C, 1'b1, 1'b0, 1'b0};
      vt[6] = '{8'd3,   8'd0,   4'd4,  4'd8, 16'h0000, 1'b0, 1'b1, 1'b0};
      vt[7] = '{8'h0F,  8'hF0,  4'd8,  4'd9, 16'h00FF, 1'b0, 1'b0, 1'b0};

      en = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
      cmd_a = '0; cmd_b = '0; cmd_s = '0; cmd_tag = '0;
      repeat (3) step();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu", {alu_a, alu_b, alu_s}, 0);
      chk("rst_res", {res_y, res_carry, res_zero, res_err, res_tag}, 0);
      en = 1'b0;
      step();
      chk("cmd_ready_after_rst", cmd_ready, 1);

      // End-to-end latency: accept at k, issue at k+1, result visible after k+4.
      res_ready = 1'b1;
      expect_res(16'h00FF, 0, 0, 0, 4'd2);
      send(8'd15, 8'd17, 4'd4, 4'd2);
      chk("lat_valid_k0", res_valid, 0);
      step();
      chk("lat_alu_as", {alu_a, alu_s}, {8'd15, 4'd4});
      chk("lat_valid_k1", res_valid, 0);
      step();
      chk("lat_valid_k2", res_valid, 0);
      step();
      chk("lat_valid_k3", res_valid, 0);
      step();
      chk("lat_valid_k4", res_valid, 1);
      wait_drain();
      chk("idle_busy", busy, 0);

      for (int i = 0; i < 8; i++) begin
         expect_res(vt[i].y, vt[i].c, vt[i].z, vt[i].e, vt[i].tag);
         send(vt[i].a, vt[i].b, vt[i].s, vt[i].tag);
         wait_drain();
      end

      // Divide-by-zero trap followed by a legal divide, back to back.
      expect_res(16'hFFFF, 0, 0, 1, 4'd3);
      expect_res(16'd14, 0, 0, 0, 4'd4);
      send(8'd9, 8'd0, 4'd5, 4'd3);
      send(8'd100, 8'd7, 4'd5, 4'd4);
      chk("trap_alu_b", alu_b, 1);
      chk("trap_alu_a", alu_a, 9);
      step();
      chk("div_alu_b", alu_b, 7);
      wait_drain();

      // Four back-to-back commands give results on consecutive cycles.
      rx_cyc.delete();
      for (int i = 0; i < 4; i++) expect_res(16'(8'd1 + 8'(i)), 0, 0, 0, TAG_W'(i + 10));
      for (int i = 0; i < 4; i++) send(8'd1, 8'(i), 4'd0, TAG_W'(i + 10));
      wait_drain();
      chk("b2b_count", rx_cyc.size(), 4);
      if (rx_cyc.size() == 4)
         for (int i = 0; i < 3; i++) chk("b2b_spacing", rx_cyc[i+1] - rx_cyc[i], 1);

      // Backpressure: 4 outstanding results plus 4 queued commands, then drain.
      res_ready = 1'b0;
      rx_cyc.delete();
      idx = 0;
      for (int c = 0; c < 30; c++) begin
         if (idx < 10) begin
            cmd_valid = 1'b1; cmd_a = 8'(8'h10 + idx); cmd_b = 8'(idx);
            cmd_s = 4'd0; cmd_tag = TAG_W'(idx);
            rdy = cmd_ready;
         end else begin
            cmd_valid = 1'b0;
            rdy = 0;
         end
         step();
         if (rdy) begin
            expect_res(16'(8'h10 + 2*idx), 0, 0, 0, TAG_W'(idx));
            idx++;
         end
      end
      cmd_valid = 1'b0;
      chk("bp_accepted", idx, 8);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_last_issue_a", alu_a, 8'h13);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_busy", busy, 1);
      res_ready = 1'b1;
      wait_drain();
      chk("bp_results", rx_cyc.size(), 8);

      // Reset mid-operation with commands queued, in flight and buffered.
      res_ready = 1'b0;
      rx_cyc.delete();
      for (int i = 0; i < 6; i++) send(8'(8'h40 + i), 8'd1, 4'd0, TAG_W'(i));
      chk("pre_rst_res_valid", res_valid, 1);
      chk("pre_rst_busy", busy, 1);
      en = 1'b1;
      step();
      en = 1'b0;
      chk("mid_rst_res_valid", res_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_alu", {alu_a, alu_b, alu_s}, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 0);
      res_ready = 1'b1;
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (res_valid !== 1'b0) hits++;
      end
      chk("post_rst_no_result", hits, 0);
      chk("post_rst_rx", rx_cyc.size(), 0);
      chk("post_rst_cmd_ready", cmd_ready, 1);

      expect_res(16'd3, 0, 0, 0, 4'd1);
      send(8'd1, 8'd2, 4'd0, 4'd1);
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
